// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register: in-order imem requests, two in flight or buffered at most.
// Response to decode in 2 cycles; stallF gates issue only, stallD holds IF/ID, jump drops stale returns.

module if_fetch_fifo #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];
endmodule

module if_fetch_stage #(
   parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        jump,
   input  logic [63:0] jump_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        validD,
   output logic [63:0] pcD,
   output logic [31:0] instD
);
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;

   logic [63:0] pc_f;
   logic [1:0]  drop_cnt;
   logic [1:0]  outstanding;
   logic [1:0]  iq_count;
   logic [2:0]  in_use;
   logic [63:0] aq_head;
   fetch_pkt_t  iq_head;
   fetch_pkt_t  iq_din;
   logic        accept;
   logic        resp;
   logic        iq_push;
   logic        iq_pop;

   // Slots are reserved at issue time so a returning instruction always has room in instQ.
   assign in_use         = {1'b0, outstanding} + {1'b0, iq_count};
   assign imem_req_valid = rst & ~jump & ~stallF & (in_use < 3'd2);
   assign imem_req_addr  = pc_f;
   assign accept         = imem_req_valid & imem_req_ready;
   assign resp           = imem_resp_valid & (outstanding != 2'd0);
   assign iq_push        = resp & ~jump & (drop_cnt == 2'd0);
   assign iq_pop         = ~flushD & ~stallD & (iq_count != 2'd0);
   assign iq_din         = '{pc: aq_head, inst: imem_resp_data};

   // addrQ occupancy is the outstanding-request count.
   if_fetch_fifo #(.W(64)) u_addr_q (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (accept),
      .pop   (resp),
      .din   (pc_f),
      .dout  (aq_head),
      .count (outstanding)
   );

   if_fetch_fifo #(.W($bits(fetch_pkt_t))) u_inst_q (
      .clk   (clk),
      .rst   (rst),
      .flush (jump),
      .push  (iq_push),
      .pop   (iq_pop),
      .din   (iq_din),
      .dout  (iq_head),
      .count (iq_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_f     <= PC_RESET;
         drop_cnt <= 2'd0;
      end else if (jump) begin
         pc_f     <= jump_target;
         drop_cnt <= outstanding - {1'b0, resp};
      end else begin
         if (accept) pc_f <= pc_f + 64'd4;
         if (resp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         validD <= 1'b0;
         pcD    <= 64'd0;
         instD  <= NOP_INST;
      end else if (flushD) begin
         validD <= 1'b0;
         pcD    <= 64'd0;
         instD  <= NOP_INST;
      end else if (!stallD) begin
         if (iq_count != 2'd0) begin
            validD <= 1'b1;
            pcD    <= iq_head.pc;
            instD  <= iq_head.inst;
         end else begin
            validD <= 1'b0;
            instD  <= NOP_INST;
         end
      end
   end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV64 core.
- Generates the PC and issues in-order requests to the instruction memory port.
- Buffers returned instructions and presents them to decode.
- Honours stallF/stallD/flushD from the hazard control unit, and jump/jump_target from the execute stage.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) driven to decode when empty or flushed

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- stallF  in  1  inhibit issuing new fetch requests
- stallD  in  1  hold IF/ID register contents
- flushD  in  1  invalidate IF/ID register (asserted with jump)
- jump  in  1  redirect fetch this cycle
- jump_target  in  64  redirect address, 4-byte aligned
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address
- imem_resp_valid  in  1  instruction return, in request order, ≥1 cycle after acceptance
- imem_resp_data  in  32  returned instruction
- validD  out  1  IF/ID holds a real instruction
- pcD  out  64  PC of instD
- instD  out  32  instruction to decode

Behaviour:
- Reset (rst==0 at edge):
  - pcF←PC_RESET; outstanding←0; drop_cnt←0; both queues empty.
  - validD←0, pcD←0, instD←NOP_INST.
  - imem_req_valid is 0 during reset cycles.
- Capacity: two internal 2-entry FIFOs.
  - addrQ: PCs of accepted, unanswered requests.
  - instQ: {pc, inst} pairs awaiting decode.
  - Invariant: outstanding + instQ count ≤ 2.
- Issue: imem_req_valid = rst & ~jump & ~stallF & (outstanding+instQ_count < 2); imem_req_addr = pcF.
- Accept (valid&ready): push pcF to addrQ, outstanding++, pcF←pcF+4 (64-bit wrap, no overflow flag).
- Response with drop_cnt==0:
  - Pop addrQ head, push {head, imem_resp_data} into instQ, outstanding--.
  - A response with outstanding==0 is ignored.
- Response with drop_cnt>0: discard data, pop addrQ, drop_cnt--, outstanding--.
- Simultaneous accept and response in one cycle: outstanding unchanged; both queue operations performed.
- Jump (highest priority):
  - pcF←jump_target; instQ flushed.
  - drop_cnt←outstanding−imem_resp_valid; a response arriving in the jump cycle is itself discarded.
  - No request is issued in the jump cycle.
  - First request to jump_target is issued the following cycle.
- IF/ID register update priority:
  - flushD: validD←0, pcD←0, instD←NOP_INST; no instQ pop.
  - else stallD: hold all three; no pop.
  - else instQ non-empty: load head, validD←1, pop.
  - else: validD←0, instD←NOP_INST, pcD held.
- Latency:
  - Response in cycle N is written to instQ at the end of N.
  - It reaches pcD/instD at the end of N+1 (no bypass).
  - Back-to-back responses sustain one instruction per cycle when stallD is low.
- stallF only gates new requests; in-flight responses still land in instQ.
- Reset mid-operation clears all state; the memory is reset by the same rst.

Test Plan:
1. Reset release, ready=1, 1-cycle memory, no stalls → addresses 0x80000000, 0x80000004, 0x80000008… issued. First validD=1 with pcD=0x80000000 two cycles after the first response. Thereafter one instruction per cycle in order.
2. imem_req_ready=0 for 5 cycles → imem_req_addr holds 0x80000000 with valid=1. pcF does not advance. validD stays 0.
3. stallD=1 for 3 cycles during streaming → pcD/instD frozen. At most 2 requests outstanding+buffered, so imem_req_valid drops. No instruction lost or duplicated after release.
4. jump=1, target 0x80000100, with 2 requests outstanding → both old responses discarded. Next validD instruction has pcD=0x80000100. flushD cycle shows validD=0, instD=0x00000013.
5. jump coincident with imem_resp_valid and stallD=1 → that response is discarded, flush overrides stall, drop_cnt=outstanding−1.
6. rst=0 asserted mid-stream with 2 outstanding → next cycle: validD=0, imem_req_valid=0, queues empty. After release, fetch restarts at 0x80000000.
